rx_sipo: RTL
============

RX_SIPO -- requirements
Module: rx_sipo

Interface
REQ-001 Parameter OVERSAMPLE, default 16: baud_tick pulses per serial bit period.
REQ-002 Parameter FRAME_BITS, default 11: start + 8 data + parity + stop.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 baud_tick  input  1  one-clock enable pulse at OVERSAMPLE x baud rate.
REQ-006 data_tx  input  1  asynchronous serial line, idle high.
REQ-007 data_parll  output  FRAME_BITS  captured frame; first received bit (start) at MSB [10], stop bit at [0].
REQ-008 active_flag  output  1  high while a frame is being received.
REQ-009 recieved_flag  output  1  high when data_parll holds a complete frame; consumed level-sensitively by the deframing stage.
REQ-010 frame_error  output  1  high when the captured stop bit sampled 0; qualified by recieved_flag.

Function
REQ-011 data_tx SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value only.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; state, tick_cnt (4 bit) and bit_cnt (4 bit) change only on clock edges where baud_tick=1, except reset.
REQ-013 IDLE: on a tick with synchronized line 0 -> START, tick_cnt=0.
REQ-014 START: tick_cnt increments per tick; at tick_cnt=7 (mid-bit): line 0 -> DATA, shift start bit in, tick_cnt=0, bit_cnt=1; line 1 -> IDLE (false start), no output change.
REQ-015 DATA: at tick_cnt=15 sample line, shift left with new bit into [0], tick_cnt wraps to 0, bit_cnt++; when bit_cnt reaches FRAME_BITS-1 -> STOP.
REQ-016 STOP: at tick_cnt=15 sample and shift the stop bit, set recieved_flag=1, frame_error=~sampled bit, -> IDLE.
REQ-017 data_parll SHALL remain stable from the recieved_flag rising edge until the next validated start bit (START->DATA transition).
REQ-018 recieved_flag SHALL stay high until that START->DATA transition, then clear in the same cycle the shift register begins reloading; a false start SHALL NOT clear it.
REQ-019 active_flag SHALL equal (state != IDLE), registered.
REQ-020 Stop bit of 0 SHALL still complete the frame (no hunting); IDLE then requires line low on a tick to restart.
REQ-021 Ticks arriving while baud_tick is gated low SHALL not advance counters; line changes between ticks are ignored.

Reset
REQ-022 reset_n low SHALL immediately force: state IDLE, tick_cnt 0, bit_cnt 0, synchronizer flops 1, data_parll all 1s, active_flag 0, recieved_flag 0, frame_error 0.
REQ-023 Reset mid-frame SHALL discard the partial frame; first frame after release requires a fresh falling edge.

Structure
REQ-024 Shared uart_rx package SHALL hold FRAME_BITS, OVERSAMPLE, MID_SAMPLE (7) and the state encoding.
REQ-025 Synchronizer SHALL be sub-module sync_2ff; all else inline in rx_sipo.

Verification
REQ-026 Frame 0xA5, parity 0, stop 1, 16 ticks/bit -> recieved_flag=1, data_parll=11'h295, frame_error=0, active_flag low afterwards.
REQ-027 Line low for 4 ticks then high -> returns IDLE, recieved_flag and data_parll unchanged, active_flag pulse only.
REQ-028 Frame 0x3C with stop bit 0 -> recieved_flag=1, frame_error=1, data_parll[0]=0.
REQ-029 reset_n low at bit_cnt=5 -> all outputs at reset values same cycle; next clean 0xFF frame captured as 11'h3FD with parity 0.
REQ-030 Back-to-back 0x00 then 0xFF (no idle gap) -> both captured; recieved_flag drops on second start validation and rises again with 11'h3FD.
REQ-031 baud_tick held low for 100 clocks mid-frame -> no state, counter or output change.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: frame geometry, mid-bit sample point and
// the receive FSM state encoding.
package uart_rx_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rx_sipo_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle-high level so no false start is seen coming out of reset.
module sync_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic data_in,
  output logic data_out
);

  logic meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta     <= 1'b1;
      data_out <= 1'b1;
    end else begin
      meta     <= data_in;
      data_out <= meta;
    end
  end

endmodule

// File: rtl/rx_sipo.sv
// Oversampled serial-in/parallel-out frame receiver: validates the start bit
// at mid-bit, then samples each remaining bit once per bit period.
module rx_sipo #(
  parameter int unsigned OVERSAMPLE = uart_rx_pkg::OVERSAMPLE,
  parameter int unsigned FRAME_BITS = uart_rx_pkg::FRAME_BITS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  baud_tick,
  input  logic                  data_tx,
  output logic [FRAME_BITS-1:0] data_parll,
  output logic                  active_flag,
  output logic                  recieved_flag,
  output logic                  frame_error
);

  import uart_rx_pkg::*;

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE);
  localparam logic [3:0] LAST_BIT  = 4'(FRAME_BITS - 1);

  rx_state_t             state, state_n;
  logic [3:0]            tick_cnt, tick_n;
  logic [3:0]            bit_cnt, bit_n;
  logic [FRAME_BITS-1:0] shreg_n;
  logic                  rcv_n, ferr_n;
  logic                  line;

  sync_2ff u_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .data_in  (data_tx),
    .data_out (line)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      data_parll    <= '1;
      active_flag   <= 1'b0;
      recieved_flag <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      state         <= state_n;
      tick_cnt      <= tick_n;
      bit_cnt       <= bit_n;
      data_parll    <= shreg_n;
      active_flag   <= (state_n != IDLE);
      recieved_flag <= rcv_n;
      frame_error   <= ferr_n;
    end
  end

  // The previous frame stays visible until a new start bit is validated.
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shreg_n = data_parll;
    rcv_n   = recieved_flag;
    ferr_n  = frame_error;
    if (baud_tick) begin
      case (state)
        IDLE: begin
          if (!line) begin
            state_n = START;
            tick_n  = '0;
          end
        end
        START: begin
          if (tick_cnt == MID_TICK) begin
            tick_n = '0;
            if (!line) begin
              state_n = DATA;
              shreg_n = {data_parll[FRAME_BITS-2:0], line};
              bit_n   = 4'd1;
              rcv_n   = 1'b0;
              ferr_n  = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_n = tick_cnt + 4'd1;
          end
        end
        DATA: begin
          if (tick_cnt == LAST_TICK) begin
            shreg_n = {data_parll[FRAME_BITS-2:0], line};
            tick_n  = '0;
            bit_n   = bit_cnt + 4'd1;
            if (bit_n == LAST_BIT) state_n = STOP;
          end else begin
            tick_n = tick_cnt + 4'd1;
          end
        end
        STOP: begin
          if (tick_cnt == LAST_TICK) begin
            shreg_n = {data_parll[FRAME_BITS-2:0], line};
            rcv_n   = 1'b1;
            ferr_n  = ~line;
            state_n = IDLE;
            tick_n  = '0;
            bit_n   = '0;
          end else begin
            tick_n = tick_cnt + 4'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
